// File: rtl/gpu_ram_seq.sv
// SDRAM slot sequencer: free-running cyc/phase/phase-counter timebase for one
// video line (286 phases x 4 banks x 4 clocks = 4576 clocks), refresh window,
// start-of-line pulse and fixed per-access slot ownership decode.
// Latency: all outputs registered; counters start two clocks after ram_ena is first seen high.
// Backpressure: none; free-running once started, only bus_rst stops it.
//
// Ports:
//   bus_clk, bus_rst      clock and synchronous active-high reset
//   ram_ena               SDRAM init done; starts the sequencer (later deassertion ignored)
//   ram_run               sequencer running
//   ram_cyc / ram_ph      one-hot clock-in-access / bank-in-phase
//   ram_ph_ctr            phase index in line, 0..PH_LAST
//   ram_ref / ram_sol     refresh window / start-of-line pulse
//   slot_*                owner of the current bank access
module gpu_ram_seq #(
    parameter int unsigned PH_LAST   = 285,
    parameter int unsigned REF_FIRST = 284,
    parameter int unsigned SPR_LAST  = 127,
    parameter int unsigned MAP_LAST  = 7,
    parameter int unsigned TILE_LAST = 39,
    parameter int unsigned CHAR_LAST = 71
) (
    input  logic       bus_clk,
    input  logic       bus_rst,
    input  logic       ram_ena,
    output logic       ram_run,
    output logic [3:0] ram_cyc,
    output logic [3:0] ram_ph,
    output logic [8:0] ram_ph_ctr,
    output logic       ram_ref,
    output logic       ram_sol,
    output logic       slot_z80,
    output logic       slot_spr,
    output logic       slot_map,
    output logic       slot_tile,
    output logic       slot_char
);

    localparam logic [8:0] PH_LAST_C   = 9'(PH_LAST);
    localparam logic [8:0] REF_FIRST_C = 9'(REF_FIRST);
    localparam logic [8:0] SPR_LAST_C  = 9'(SPR_LAST);
    localparam logic [8:0] MAP_LAST_C  = 9'(MAP_LAST);
    localparam logic [8:0] TILE_LAST_C = 9'(TILE_LAST);
    localparam logic [8:0] CHAR_LAST_C = 9'(CHAR_LAST);

    // Counters advance only from the clock after ram_run rose, so the first
    // running cycle presents the line origin together with ram_sol.
    logic       started;

    logic [3:0] cyc_nxt;
    logic [3:0] ph_nxt;
    logic [8:0] ctr_nxt;
    logic       ref_nxt;
    logic       sol_nxt;
    logic       z80_nxt;
    logic       spr_nxt;
    logic       map_nxt;
    logic       tile_nxt;
    logic       char_nxt;

    // Everything derived from the next counter state, so flags are registered
    // on the same edge as the counters they describe.
    always_comb begin
        cyc_nxt = ram_cyc;
        ph_nxt  = ram_ph;
        ctr_nxt = ram_ph_ctr;
        if (started) begin
            cyc_nxt = {ram_cyc[2:0], ram_cyc[3]};
            if (ram_cyc[3]) begin
                ph_nxt = {ram_ph[2:0], ram_ph[3]};
                if (ram_ph[3]) begin
                    ctr_nxt = (ram_ph_ctr >= PH_LAST_C) ? 9'd0 : ram_ph_ctr + 9'd1;
                end
            end
        end

        ref_nxt  = ram_run && (ctr_nxt >= REF_FIRST_C);
        sol_nxt  = ram_run && (ctr_nxt == 9'd0) && (ph_nxt == 4'b0001) && (cyc_nxt == 4'b0001);
        z80_nxt  = ram_run && (ph_nxt[0] || ph_nxt[2]) && !ref_nxt;
        spr_nxt  = ram_run && ph_nxt[1] && (ctr_nxt <= SPR_LAST_C) && !ref_nxt;
        map_nxt  = ram_run && ph_nxt[3] && (ctr_nxt <= MAP_LAST_C) && !ref_nxt;
        tile_nxt = ram_run && ph_nxt[3] && (ctr_nxt > MAP_LAST_C)
                   && (ctr_nxt <= TILE_LAST_C) && !ref_nxt;
        char_nxt = ram_run && ph_nxt[3] && (ctr_nxt > TILE_LAST_C)
                   && (ctr_nxt <= CHAR_LAST_C) && !ref_nxt;
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            ram_run    <= 1'b0;
            started    <= 1'b0;
            ram_cyc    <= 4'b0001;
            ram_ph     <= 4'b0001;
            ram_ph_ctr <= 9'd0;
            ram_ref    <= 1'b0;
            ram_sol    <= 1'b0;
            slot_z80   <= 1'b0;
            slot_spr   <= 1'b0;
            slot_map   <= 1'b0;
            slot_tile  <= 1'b0;
            slot_char  <= 1'b0;
        end else begin
            ram_run    <= ram_run | ram_ena;
            started    <= ram_run;
            ram_cyc    <= cyc_nxt;
            ram_ph     <= ph_nxt;
            ram_ph_ctr <= ctr_nxt;
            ram_ref    <= ref_nxt;
            ram_sol    <= sol_nxt;
            slot_z80   <= z80_nxt;
            slot_spr   <= spr_nxt;
            slot_map   <= map_nxt;
            slot_tile  <= tile_nxt;
            slot_char  <= char_nxt;
        end
    end

endmodule
